// File: rtl/serdes_rx_framer.sv
// Serial receive framer: hunts for SYNC_WORD, frames payload bytes MSB first, and buffers them in a show-ahead FIFO.
// Optional macro SERDES_RX_ERR_CNT_EN adds a saturating err_cnt output (sync misses plus dropped bytes).
module serdes_rx_framer #(
    parameter logic [7:0] SYNC_WORD  = 8'h81,
    parameter int         DATA_BYTES = 1,
    parameter int         MAX_MISS   = 3,
    parameter int         FIFO_DEPTH = 4,
    parameter int         DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        serial_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        sync_err,
    output logic        overflow
`ifdef SERDES_RX_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC_CHK} state_t;

    localparam logic [7:0]          LAST_BYTE = 8'(DATA_BYTES - 1);
    localparam logic [3:0]          MISS_LAST = 4'(MAX_MISS - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    state_t                state;
    logic [6:0]            sr;
    logic [2:0]            bit_cnt;
    logic [7:0]            byte_cnt;
    logic [3:0]            miss_cnt;

    logic [7:0]            mem [FIFO_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic [7:0] next_byte;
    logic       byte_done;
    logic       push;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       drop;
    logic       sync_miss;

    // The byte completing on this bit_en, including the bit being sampled now.
    assign next_byte = {sr, serial_in};
    assign byte_done = bit_en && (state != HUNT) && (bit_cnt == 3'd7);
    assign push      = byte_done && (state == PAYLOAD);
    assign sync_miss = byte_done && (state == SYNC_CHK) && (next_byte != SYNC_WORD);

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            sr       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (bit_en) begin
                sr <= next_byte[6:0];
                case (state)
                    HUNT: begin
                        if (next_byte == SYNC_WORD) begin
                            state    <= PAYLOAD;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            miss_cnt <= '0;
                            locked   <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == LAST_BYTE) begin
                                byte_cnt <= '0;
                                state    <= SYNC_CHK;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end
                    end
                    SYNC_CHK: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (next_byte == SYNC_WORD) begin
                                miss_cnt <= '0;
                                state    <= PAYLOAD;
                            end else begin
                                sync_err <= 1'b1;
                                // Flywheel through isolated misses; only a full run of them drops lock.
                                if (miss_cnt == MISS_LAST) begin
                                    miss_cnt <= '0;
                                    locked   <= 1'b0;
                                    state    <= HUNT;
                                end else begin
                                    miss_cnt <= miss_cnt + 4'd1;
                                    state    <= PAYLOAD;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= next_byte;
    end

`ifdef SERDES_RX_ERR_CNT_EN
    // A sync miss and a dropped byte come from different states, so one increment covers both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if ((sync_miss || drop) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
